// File: rtl/cpu_loader_pkg.sv
// Shared types and helpers for the cpu_loader session controller.
package cpu_loader_pkg;

  localparam int IDX_W          = 11;
  localparam int IMEM_WORDS_DEF = 512;
  localparam int DMEM_WORDS_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN,
    DUMP_REQ,
    DUMP_HOLD,
    DONE
  } state_e;

  // Clamp a requested word count to the memory depth.
  function automatic logic [IDX_W-1:0] clamp_len(input logic [IDX_W-1:0] len,
                                                 input int unsigned      max);
    logic [IDX_W-1:0] m;
    m = IDX_W'(max);
    return (len > m) ? m : len;
  endfunction

  // Next phase after 'cur', skipping every phase whose count is zero.
  function automatic state_e seq_after(input state_e cur, input logic i_nz,
                                       input logic d_nz, input logic r_nz,
                                       input logic p_nz);
    logic before_d, before_r, before_p;
    before_d = (cur == IDLE) || (cur == LOAD_I);
    before_r = before_d || (cur == LOAD_D);
    before_p = before_r || (cur == RUN);
    if ((cur == IDLE) && i_nz) return LOAD_I;
    if (before_d && d_nz)      return LOAD_D;
    if (before_r && r_nz)      return RUN;
    if (before_p && p_nz)      return DUMP_REQ;
    return DONE;
  endfunction

endpackage

// File: rtl/loader_counter.sv
// Loadable up/down counter with sync clear and a terminal-match flag.
module loader_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         hit
);

  // Clear wins over load, load wins over count.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (en)  cnt <= up ? cnt + W'(1) : cnt - W'(1);
  end

  assign hit = (cnt == term);

endmodule

// File: rtl/cpu_loader.sv
// Host session controller: load imem/dmem, run the CPU, dump dmem.
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int ADDR_SHIFT = 2,
  parameter int RUN_W      = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [9:0]       imem_len,
  input  logic [10:0]      dmem_len,
  input  logic [10:0]      dump_len,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             cpu_enable,
  output logic [31:0]      imem_addr,
  output logic             imem_wen,
  output logic             imem_ren,
  output logic [31:0]      imem_wdata,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      dmem_addr,
  output logic             dmem_wen,
  output logic             dmem_ren,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  output logic             busy,
  output logic             done
);

  state_e state_q, state_d;

  logic [IDX_W-1:0] ilen_q, dlen_q, plen_q;
  logic [IDX_W-1:0] ilen_c, dlen_c, plen_c;
  logic [IDX_W-1:0] idx, idx_term;
  logic             idx_hit, idx_en, idx_clr;
  logic [RUN_W-1:0] run_cnt;
  logic             run_hit, run_ld, run_en;
  logic             rd_pend;
  logic             unused_imem_rdata;

  // The loader only writes imem; its read data is never needed.
  assign unused_imem_rdata = ^imem_rdata;

  assign ilen_c = clamp_len({1'b0, imem_len}, IMEM_WORDS);
  assign dlen_c = clamp_len(dmem_len, DMEM_WORDS);
  assign plen_c = clamp_len(dump_len, DMEM_WORDS);

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign cpu_enable = (state_q == RUN);
  assign imem_ren   = 1'b0;

  // Word index shared by both load phases and the dump phase.
  loader_counter #(.W(IDX_W)) u_idx (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (idx_clr),
    .ld     (1'b0),
    .ld_val ('0),
    .en     (idx_en),
    .up     (1'b1),
    .term   (idx_term),
    .cnt    (idx),
    .hit    (idx_hit)
  );

  // Run counter holds the latched run length until RUN, then counts to 1.
  loader_counter #(.W(RUN_W)) u_run (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (1'b0),
    .ld     (run_ld),
    .ld_val (run_cycles),
    .en     (run_en),
    .up     (1'b0),
    .term   (RUN_W'(1)),
    .cnt    (run_cnt),
    .hit    (run_hit)
  );

  // Terminal index for whichever phase is walking the index.
  always_comb begin
    idx_term = plen_q - IDX_W'(1);
    case (state_q)
      LOAD_I:  idx_term = ilen_q - IDX_W'(1);
      LOAD_D:  idx_term = dlen_q - IDX_W'(1);
      default: ;
    endcase
  end

  // State register and session length latch.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ilen_q  <= '0;
      dlen_q  <= '0;
      plen_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        ilen_q <= ilen_c;
        dlen_q <= dlen_c;
        plen_q <= plen_c;
      end
    end
  end

  // Dump read path: read data is captured the cycle after the request.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_pend <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      rd_pend <= (state_q == DUMP_REQ);
      if (rd_pend) begin
        m_data  <= dmem_rdata;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Next state, memory strobes and counter controls.
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    imem_addr  = '0;
    imem_wen   = 1'b0;
    imem_wdata = '0;
    dmem_addr  = '0;
    dmem_wen   = 1'b0;
    dmem_ren   = 1'b0;
    dmem_wdata = '0;
    idx_en     = 1'b0;
    idx_clr    = 1'b0;
    run_ld     = 1'b0;
    run_en     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        run_ld  = 1'b1;
        idx_clr = 1'b1;
        state_d = seq_after(IDLE, imem_len != '0, dmem_len != '0,
                            run_cycles != '0, dump_len != '0);
      end
      LOAD_I: begin
        s_ready = 1'b1;
        if (s_valid) begin
          imem_wen   = 1'b1;
          imem_addr  = 32'(idx) << ADDR_SHIFT;
          imem_wdata = s_data;
          idx_en     = 1'b1;
          if (idx_hit) begin
            idx_clr = 1'b1;
            state_d = seq_after(LOAD_I, 1'b1, dlen_q != '0, run_cnt != '0,
                                plen_q != '0);
          end
        end
      end
      LOAD_D: begin
        s_ready = 1'b1;
        if (s_valid) begin
          dmem_wen   = 1'b1;
          dmem_addr  = 32'(idx) << ADDR_SHIFT;
          dmem_wdata = s_data;
          idx_en     = 1'b1;
          if (idx_hit) begin
            idx_clr = 1'b1;
            state_d = seq_after(LOAD_D, 1'b1, 1'b1, run_cnt != '0,
                                plen_q != '0);
          end
        end
      end
      RUN: begin
        run_en = 1'b1;
        if (run_hit) state_d = seq_after(RUN, 1'b1, 1'b1, 1'b1, plen_q != '0);
      end
      DUMP_REQ: begin
        dmem_ren  = 1'b1;
        dmem_addr = 32'(idx) << ADDR_SHIFT;
        state_d   = DUMP_HOLD;
      end
      DUMP_HOLD: if (m_valid && m_ready) begin
        idx_en = 1'b1;
        if (idx_hit) begin
          idx_clr = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DUMP_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/cpu_loader.md
# cpu_loader

Host-side session controller sitting directly upstream of the `cpu` top. It streams a program into instruction memory and initial data into data memory through the CPU's external memory ports. It then holds `cpu_enable` high for a programmed cycle count and streams a programmed number of data-memory words back out. Outside RUN, `cpu_enable` is low, so the CPU pipeline is frozen while memories are loaded or dumped.

## Interface
- `IMEM_WORDS`, default 512: instruction memory depth in words; `imem_len` is clamped to this.
- `DMEM_WORDS`, default 1024: data memory depth in words; `dmem_len` and `dump_len` are clamped to this.
- `ADDR_SHIFT`, default 2: emitted address is word_index << ADDR_SHIFT (byte addressing).
- `RUN_W`, default 16: width of the run-cycle counter.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: session request; sampled only in IDLE.
- `imem_len` in 10: instruction words to load, 0..512.
- `dmem_len` in 11: data words to load, 0..1024.
- `dump_len` in 11: data words to read back, starting at word 0.
- `run_cycles` in RUN_W: number of cycles `cpu_enable` is high.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 32: load stream. Instruction words come first, then data words.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 32: dump stream.
- `cpu_enable` out 1: drives `cpu.enable`.
- `imem_addr` out 32, `imem_wen` out 1, `imem_ren` out 1, `imem_wdata` out 32, `imem_rdata` in 32: instruction memory external port.
- `dmem_addr` out 32, `dmem_wen` out 1, `dmem_ren` out 1, `dmem_wdata` out 32, `dmem_rdata` in 32: data memory external port.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a session.

## Operation
- **Latch.** In IDLE, `start`=1 latches all four lengths (clamped) and `run_cycles`. The lengths are ignored thereafter; `start` in any other state is ignored.
- **State sequence.** IDLE → LOAD_I → LOAD_D → RUN → DUMP_REQ ↔ DUMP_HOLD → DONE → IDLE.
  - Any state whose latched length or count is 0 is skipped. All-zero: IDLE → DONE → IDLE.
- **LOAD_I / LOAD_D.**
  - `s_ready`=1.
  - On each handshake (`s_valid` & `s_ready`), the same cycle drives:
    - `*_wen`=1 on the target memory;
    - `*_addr` = idx << ADDR_SHIFT;
    - `*_wdata` = `s_data`;
    - idx increments.
  - The handshake with idx = len-1 advances the state and clears idx.
  - `s_valid`=0 stalls without penalty.
- **RUN.**
  - `cpu_enable`=1 for exactly `run_cycles` consecutive cycles.
  - All memory `wen`/`ren` are 0.
  - `s_ready`=0 and `m_valid`=0.
- **DUMP_REQ.** `dmem_ren`=1 and `dmem_addr` = idx << ADDR_SHIFT for one cycle, then go to DUMP_HOLD.
- **DUMP_HOLD.**
  - `dmem_rdata` is valid in the cycle after `dmem_ren`. It is captured into the `m_data` register, and `m_valid` rises the cycle after that.
  - `m_data` and `m_valid` hold stable until `m_ready`.
  - On handshake: idx increments, then back to DUMP_REQ, or to DONE if the word was the last.
- **DONE.** `done`=1 for one cycle, then IDLE. Memory contents and CPU state are untouched.
- **Mutual exclusion.** `imem_ren` is never asserted. Exactly one memory strobe is asserted in any cycle, or none.

## Timing
- **Reset values.** `arst_n`=0 forces, asynchronously:
  - state = IDLE and all counters = 0;
  - every output = 0 (`s_ready`, `m_valid`, `m_data`, `cpu_enable`, all addr/wen/ren/wdata, `busy`, `done`).
- **Reset mid-session.** Abort immediately. Partially written memory is left as is; no `done` pulse.
- **Load strobes.** Write strobes are combinational from the handshake (same cycle as `s_valid`). Load throughput is 1 word/cycle.
- **Start latency.** `start` at cycle t gives `busy` and the first-state outputs at t+1.
- **Dump throughput.** The best case is 1 word per 3 cycles (REQ, capture, handshake); `m_valid` rises 2 cycles after REQ.
- **RUN to dump.** `cpu_enable` falls in the same edge that enters DUMP_REQ. The first dump read therefore sees the memory after the final enabled cycle.
- **Counter widths.** idx is 11 bits and wraps only by length clamp, never by overflow. The run counter counts down from `run_cycles` to 1.

## Structure
- Package `cpu_loader_pkg` holds:
  - the state enum (IDLE, LOAD_I, LOAD_D, RUN, DUMP_REQ, DUMP_HOLD, DONE);
  - the idx width constant;
  - the default memory depths.
- One sub-module, `loader_counter`: loadable up/down counter with an enable, a synchronous clear, and a terminal-match flag.
  - Instantiated twice: word index and run cycles.

## Test plan
- **Full session.** `imem_len`=4 (words A0..A3), `dmem_len`=2 (D0,D1), `run_cycles`=10, `dump_len`=2, `m_ready`=1 →
  - `imem_wen` at addrs 0,4,8,12 and `dmem_wen` at 0,4;
  - `cpu_enable` high exactly 10 cycles;
  - `m_data` = D0 then D1, assuming the program does not touch dmem;
  - `done` pulses once.
- **Stalls on both streams.** `s_valid` toggles 1,0,0,1 and `m_ready` is held 0 for 5 cycles → no lost or duplicated writes; `m_data` stays stable while stalled.
- **Zero lengths.** All lengths = 0 → `busy` for 1 cycle (DONE), `done` pulse, no memory strobes. `dmem_len`=0 alone → LOAD_I goes straight to RUN.
- **Clamp.** `imem_len`=600 → exactly 512 writes, last address 2044, then the state advances.
- **Reset mid-RUN.** `arst_n` pulled low at run cycle 5 → `cpu_enable`, `busy` = 0 immediately; no `done`. A new `start` after release runs a full session.
- **Start while busy.** `start` pulsed during LOAD_D → ignored; the latched lengths are unchanged.
